// File: rtl/bp_be_fp_retire_pipe_pkg.sv
// Shared types for the FP retire pipe: retire entry layout, fcsr sub-addresses
// and fflags bit positions.
package bp_be_pkg;

    localparam int reg_data_width_gp = 64;
    localparam int reg_addr_width_gp = 5;
    localparam int fflags_width_gp   = 5;

    localparam int fflags_nv_gp = 4;
    localparam int fflags_dz_gp = 3;
    localparam int fflags_of_gp = 2;
    localparam int fflags_uf_gp = 1;
    localparam int fflags_nx_gp = 0;

    typedef enum logic [1:0] {
        e_fcsr_fflags = 2'd0,
        e_fcsr_frm    = 2'd1,
        e_fcsr_full   = 2'd2
    } bp_be_fcsr_addr_e;

    typedef struct packed {
        logic                         fp_w;
        logic [reg_addr_width_gp-1:0] rd_addr;
        logic [fflags_width_gp-1:0]   fflags;
        logic [reg_data_width_gp-1:0] data;
    } bp_be_fp_retire_entry_s;

endpackage

// File: rtl/bp_be_fp_retire_pipe_if.sv
// Bundle between the FP pipe / CSR unit and the retire pipe.
interface bp_be_fp_retire_pipe_if
    import bp_be_pkg::*;
#(
    parameter int latency_p        = 4,
    parameter int reg_data_width_p = reg_data_width_gp,
    parameter int reg_addr_width_p = reg_addr_width_gp
);
    logic                                  v_i;
    logic [reg_data_width_p-1:0]           data_i;
    logic [fflags_width_gp-1:0]            fflags_i;
    logic [reg_addr_width_p-1:0]           rd_addr_i;
    logic                                  fp_w_i;
    logic                                  flush_i;
    logic                                  csr_w_v_i;
    logic [1:0]                            csr_w_addr_i;
    logic [7:0]                            csr_w_data_i;
    logic [7:0]                            fcsr_o;
    logic [2:0]                            frm_o;
    logic [latency_p-1:0]                  stage_v_o;
    logic [latency_p*reg_addr_width_p-1:0] stage_rd_o;
    logic [latency_p-1:0]                  stage_fp_o;
    logic                                  wb_v_o;
    logic                                  wb_fp_o;
    logic [reg_addr_width_p-1:0]           wb_rd_addr_o;
    logic [reg_data_width_p-1:0]           wb_data_o;

    modport master (
        output v_i, data_i, fflags_i, rd_addr_i, fp_w_i, flush_i,
               csr_w_v_i, csr_w_addr_i, csr_w_data_i,
        input  fcsr_o, frm_o, stage_v_o, stage_rd_o, stage_fp_o,
               wb_v_o, wb_fp_o, wb_rd_addr_o, wb_data_o
    );

    modport slave (
        input  v_i, data_i, fflags_i, rd_addr_i, fp_w_i, flush_i,
               csr_w_v_i, csr_w_addr_i, csr_w_data_i,
        output fcsr_o, frm_o, stage_v_o, stage_rd_o, stage_fp_o,
               wb_v_o, wb_fp_o, wb_rd_addr_o, wb_data_o
    );

endinterface

// File: rtl/bp_be_fp_retire_pipe_fcsr.sv
// Architectural fflags/frm: sticky flag accumulation from writeback, with a
// same-cycle CSR write taking priority on the fields it targets.
module bp_be_fp_fcsr
    import bp_be_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       wb_v_i,
    input  logic [fflags_width_gp-1:0] wb_fflags_i,
    input  logic                       csr_w_v_i,
    input  logic [1:0]                 csr_w_addr_i,
    input  logic [7:0]                 csr_w_data_i,
    output logic [fflags_width_gp-1:0] fflags_o,
    output logic [2:0]                 frm_o
);
    logic [fflags_width_gp-1:0] r_fflags, w_fflags_n;
    logic [2:0]                 r_frm, w_frm_n;
    bp_be_fcsr_addr_e           w_addr;

    assign w_addr = bp_be_fcsr_addr_e'(csr_w_addr_i);

    // The CSR op is younger than the retiring instruction, so it overwrites
    // rather than ORs with that instruction's flags.
    always_comb begin
        w_fflags_n = r_fflags | (wb_v_i ? wb_fflags_i : '0);
        w_frm_n    = r_frm;
        if (csr_w_v_i) begin
            case (w_addr)
                e_fcsr_fflags: w_fflags_n = csr_w_data_i[4:0];
                e_fcsr_frm:    w_frm_n    = csr_w_data_i[2:0];
                e_fcsr_full: begin
                    w_fflags_n = csr_w_data_i[4:0];
                    w_frm_n    = csr_w_data_i[7:5];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_fflags <= '0;
            r_frm    <= '0;
        end else begin
            r_fflags <= w_fflags_n;
            r_frm    <= w_frm_n;
        end
    end

    assign fflags_o = r_fflags;
    assign frm_o    = r_frm;

endmodule

// File: rtl/bp_be_fp_retire_pipe.sv
// Fixed-depth shift pipe from FP pipe output to FP/int writeback; the last
// stage is the commit point and survives a flush.
module bp_be_fp_retire_pipe
    import bp_be_pkg::*;
#(
    parameter int latency_p        = 4,
    parameter int reg_data_width_p = reg_data_width_gp,
    parameter int reg_addr_width_p = reg_addr_width_gp
)(
    input logic                    clk_i,
    input logic                    reset_i,
    bp_be_fp_retire_pipe_if.slave  io
);
    logic [latency_p-1:0]   r_v;
    bp_be_fp_retire_entry_s r_entry [latency_p];
    bp_be_fp_retire_entry_s w_in;
    logic [4:0]             w_fflags;
    logic [2:0]             w_frm;

    assign w_in = '{fp_w: io.fp_w_i, rd_addr: io.rd_addr_i,
                    fflags: io.fflags_i, data: io.data_i};

    // Flush kills every uncommitted stage, including the one about to enter
    // the commit stage and the incoming op.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_v <= '0;
        else         r_v <= {r_v[latency_p-2:0], io.v_i} & {latency_p{~io.flush_i}};
    end

    always_ff @(posedge clk_i) r_entry[0] <= w_in;

    for (genvar i = 1; i < latency_p; i++) begin : g_stage
        always_ff @(posedge clk_i) r_entry[i] <= r_entry[i-1];
    end

    for (genvar i = 0; i < latency_p; i++) begin : g_occ
        assign io.stage_rd_o[i*reg_addr_width_p +: reg_addr_width_p] = r_entry[i].rd_addr;
        assign io.stage_fp_o[i] = r_entry[i].fp_w;
    end

    assign io.stage_v_o    = r_v;
    assign io.wb_v_o       = r_v[latency_p-1];
    assign io.wb_fp_o      = r_entry[latency_p-1].fp_w;
    assign io.wb_rd_addr_o = r_entry[latency_p-1].rd_addr;
    assign io.wb_data_o    = r_entry[latency_p-1].data;

    bp_be_fp_fcsr u_fcsr (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .wb_v_i       (r_v[latency_p-1]),
        .wb_fflags_i  (r_entry[latency_p-1].fflags),
        .csr_w_v_i    (io.csr_w_v_i),
        .csr_w_addr_i (io.csr_w_addr_i),
        .csr_w_data_i (io.csr_w_data_i),
        .fflags_o     (w_fflags),
        .frm_o        (w_frm)
    );

    assign io.frm_o  = w_frm;
    assign io.fcsr_o = {w_frm, w_fflags};

endmodule

// File: tb/tb_bp_be_fp_retire_pipe.sv
// Random + directed bench for bp_be_fp_retire_pipe against an age-based op model.
module tb_bp_be_fp_retire_pipe;
    import bp_be_pkg::*;

    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_be_fp_retire_pipe_if #(.latency_p(L)) io ();

    bp_be_fp_retire_pipe #(.latency_p(L)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .io      (io.slave)
    );

    typedef struct {
        int        age;
        bit        fp;
        bit [4:0]  rd;
        bit [63:0] data;
        bit [4:0]  flags;
    } op_t;

    op_t      q[$];
    bit [4:0] m_fflags = '0;
    bit [2:0] m_frm = '0;
    int       n_chk = 0;
    int       n_pass = 0;
    int       wb_seen = 0;
    int       mark;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic idle();
        io.v_i = 1'b0; io.flush_i = 1'b0; io.csr_w_v_i = 1'b0;
        io.csr_w_addr_i = '0; io.csr_w_data_i = '0;
    endtask

    task automatic op(input bit [4:0] rd, input bit fp, input bit [63:0] d, input bit [4:0] f);
        io.v_i = 1'b1; io.rd_addr_i = rd; io.fp_w_i = fp; io.data_i = d; io.fflags_i = f;
    endtask

    task automatic csr(input bit [1:0] a, input bit [7:0] d);
        io.csr_w_v_i = 1'b1; io.csr_w_addr_i = a; io.csr_w_data_i = d;
    endtask

    // An op retires when its age reaches L-1; every edge ages the rest by one.
    task automatic model_edge();
        op_t      nq[$];
        op_t      n;
        bit [4:0] f_n;
        bit [2:0] r_n;
        f_n = m_fflags;
        r_n = m_frm;
        foreach (q[i]) if (q[i].age == L-1) f_n |= q[i].flags;
        if (io.csr_w_v_i) begin
            if (io.csr_w_addr_i == 2'd0 || io.csr_w_addr_i == 2'd2) f_n = io.csr_w_data_i[4:0];
            if (io.csr_w_addr_i == 2'd1) r_n = io.csr_w_data_i[2:0];
            if (io.csr_w_addr_i == 2'd2) r_n = io.csr_w_data_i[7:5];
        end
        m_fflags = f_n;
        m_frm = r_n;
        foreach (q[i]) begin
            if (q[i].age != L-1 && !io.flush_i) begin
                n = q[i];
                n.age++;
                nq.push_back(n);
            end
        end
        if (io.v_i && !io.flush_i) begin
            n.age = 0; n.fp = io.fp_w_i; n.rd = io.rd_addr_i;
            n.data = io.data_i; n.flags = io.fflags_i;
            nq.push_back(n);
        end
        q = nq;
    endtask

    task automatic check_all();
        bit [L-1:0] ev;
        bit         wb;
        op_t        w;
        ev = '0;
        wb = 1'b0;
        foreach (q[i]) begin
            ev[q[i].age] = 1'b1;
            chk("stage_rd", io.stage_rd_o[q[i].age*5 +: 5], q[i].rd);
            chk("stage_fp", io.stage_fp_o[q[i].age], q[i].fp);
            if (q[i].age == L-1) begin wb = 1'b1; w = q[i]; end
        end
        chk("stage_v", io.stage_v_o, ev);
        chk("wb_v", io.wb_v_o, wb);
        chk("fcsr", io.fcsr_o, {m_frm, m_fflags});
        chk("frm", io.frm_o, m_frm);
        if (wb) begin
            chk("wb_rd", io.wb_rd_addr_o, w.rd);
            chk("wb_fp", io.wb_fp_o, w.fp);
            chk("wb_data", io.wb_data_o, w.data);
        end
        if (io.wb_v_o) wb_seen++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        idle();
    endtask

    initial begin
        idle();
        io.rd_addr_i = '0; io.fp_w_i = 1'b0; io.data_i = '0; io.fflags_i = '0;
        #1;
        chk("rst_stage_v", io.stage_v_o, '0);
        chk("rst_fcsr", io.fcsr_o, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_v", io.wb_v_o, 1'b0);
        rst = 1'b0;

        // single op
        op(5'd7, 1'b1, 64'h3FF0000000000000, 5'h01); step();
        repeat (3) step();
        chk("single_wb_v", io.wb_v_o, 1'b1);
        chk("single_wb_data", io.wb_data_o, 64'h3FF0000000000000);
        chk("single_wb_rd", io.wb_rd_addr_o, 5'd7);
        step();
        chk("single_fflags", io.fcsr_o[4:0], 5'h01);

        // back-to-back
        csr(2'd0, 8'h00); step();
        op(5'd1, 1'b1, 64'h11, 5'h01); step();
        op(5'd2, 1'b0, 64'h22, 5'h02); step();
        op(5'd3, 1'b1, 64'h33, 5'h04); step();
        op(5'd4, 1'b0, 64'h44, 5'h10); step();
        repeat (5) step();
        chk("b2b_fflags", io.fcsr_o[4:0], 5'h17);

        // flush with A in stage 2: nothing retires
        mark = wb_seen;
        op(5'd10, 1'b1, 64'hA, 5'h08); step();
        op(5'd11, 1'b1, 64'hB, 5'h08); step();
        op(5'd12, 1'b1, 64'hC, 5'h08); step();
        io.flush_i = 1'b1; step();
        repeat (5) step();
        chk("flush3_wb_cnt", wb_seen - mark, 0);
        chk("flush3_fflags", io.fcsr_o[4:0], 5'h17);

        // flush with A in stage 3: only A retires
        csr(2'd0, 8'h00); step();
        mark = wb_seen;
        op(5'd10, 1'b1, 64'hA, 5'h08); step();
        op(5'd11, 1'b1, 64'hB, 5'h01); step();
        op(5'd12, 1'b1, 64'hC, 5'h01); step();
        step();
        io.flush_i = 1'b1; step();
        repeat (5) step();
        chk("flush4_wb_cnt", wb_seen - mark, 1);
        chk("flush4_fflags", io.fcsr_o[4:0], 5'h08);

        // CSR write to fflags collides with writeback
        csr(2'd0, 8'h1F); step();
        op(5'd5, 1'b1, 64'h55, 5'h04); step();
        repeat (3) step();
        chk("coll0_wb_v", io.wb_v_o, 1'b1);
        csr(2'd0, 8'h00); step();
        chk("coll0_fflags", io.fcsr_o[4:0], 5'h00);

        // CSR write to frm collides with writeback
        op(5'd6, 1'b1, 64'h66, 5'h04); step();
        repeat (3) step();
        csr(2'd1, 8'h03); step();
        chk("coll1_frm", io.frm_o, 3'd3);
        chk("coll1_fflags", io.fcsr_o[4:0], 5'h04);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) < 60)
                op(5'($urandom), 1'($urandom), {$urandom, $urandom}, 5'($urandom));
            if ($urandom_range(0, 99) < 6) io.flush_i = 1'b1;
            if ($urandom_range(0, 99) < 8) csr(2'($urandom), 8'($urandom));
            step();
        end

        // async reset with three ops in flight
        op(5'd20, 1'b1, 64'h1, 5'h01); step();
        op(5'd21, 1'b1, 64'h2, 5'h02); step();
        op(5'd22, 1'b1, 64'h3, 5'h04); step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_stage_v", io.stage_v_o, '0);
        chk("arst_wb_v", io.wb_v_o, 1'b0);
        chk("arst_fcsr", io.fcsr_o, 8'h00);
        q.delete();
        m_fflags = '0;
        m_frm = '0;
        #1;
        rst = 1'b0;
        mark = wb_seen;
        repeat (6) step();
        chk("arst_no_wb", wb_seen - mark, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
